mem_stage: RTL and testbench

Memory-access stage of the 16-bit CPU pipeline, sitting between execute and writeback. It consumes execute's registered outputs (ALU result, store data, destination, control bits) and performs data-memory reads and writes or external-bus reads over request/grant/valid handshakes. It stalls upstream while an access is outstanding and presents a registered writeback/forwarding result.

---
 rtl/mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_mem_stage.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 16-bit pipeline (execute -> writeback).
// Runs data-memory reads/writes and external-bus reads over req/gnt/valid
// handshakes. It stalls upstream while an access is outstanding and registers
// the writeback/forward result.
// Optional feature macro: MEM_TIMEOUT_EN. It aborts an access that waits
// TIMEOUT_CYCLES in REQ/RESP/BUS and raises the sticky oMemErr.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] iAluOut,
    input  logic [15:0] iData2,
    input  logic [3:0]  iDest,
    input  logic        iAlutoReg,
    input  logic        iMemtoReg,
    input  logic        iBustoReg,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    output logic        oStall,
    output logic        oMemReq,
    output logic        oMemWe,
    output logic [15:0] oMemAddr,
    output logic [15:0] oMemWdata,
    input  logic        iMemGnt,
    input  logic        iMemRvalid,
    input  logic [15:0] iMemRdata,
    output logic        oBusReq,
    output logic [15:0] oBusAddr,
    input  logic        iBusValid,
    input  logic [15:0] iBusData,
    output logic [15:0] oWbData,
    output logic [3:0]  oWbDest,
    output logic        oWbEn,
    output logic        oMemErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        BUS  = 2'd3
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [15:0] wbDataNext;
    logic        wbEnNext;
    logic        timeoutHit;
    logic        abortNow;
    logic        memRd;
    logic        memWr;
    logic        unusedMemtoReg;

    // The writeback source is fixed by the operation being retired, so the
    // memory-to-register select carries no extra information here.
    assign unusedMemtoReg = iMemtoReg;

    // A read outranks a write when both are set on one instruction.
    assign memRd = iMemRead;
    assign memWr = ~iMemRead & iMemWrite;

    assign oMemAddr  = iAluOut;
    assign oMemWdata = iData2;
    assign oBusAddr  = iAluOut;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] timeoutCnt;

    assign timeoutHit = (timeoutCnt == 8'(TIMEOUT_CYCLES));

    // The wait counter restarts on entry to each waiting state and counts every cycle spent there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeoutCnt <= 8'd0;
        end else if ((nextState != state) && (nextState != IDLE)) begin
            timeoutCnt <= 8'd0;
        end else if (state != IDLE) begin
            timeoutCnt <= timeoutCnt + 8'd1;
        end
    end

    // The error flag is sticky: once an access is aborted it stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oMemErr <= 1'b0;
        end else if (abortNow) begin
            oMemErr <= 1'b1;
        end
    end
`else
    logic unusedTimeoutParam;

    assign unusedTimeoutParam = ^TIMEOUT_CYCLES;
    assign timeoutHit         = 1'b0;
    assign oMemErr            = 1'b0;
`endif

    // State register and writeback register. A stalled cycle inserts a bubble and holds the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            oWbData <= 16'd0;
            oWbDest <= 4'd0;
            oWbEn   <= 1'b0;
        end else begin
            state <= nextState;
            if (oStall) begin
                oWbEn <= 1'b0;
            end else begin
                oWbData <= wbDataNext;
                oWbDest <= iDest;
                oWbEn   <= wbEnNext;
            end
        end
    end

    // Next-state, handshake and stall logic. Holding reset forces every request and the stall low.
    always_comb begin
        nextState  = state;
        oStall     = 1'b0;
        oMemReq    = 1'b0;
        oMemWe     = 1'b0;
        oBusReq    = 1'b0;
        wbDataNext = iAluOut;
        wbEnNext   = 1'b0;
        abortNow   = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (memRd || memWr) begin
                        oMemReq = 1'b1;
                        oMemWe  = memWr;
                        if (!iMemGnt) begin
                            oStall    = 1'b1;
                            nextState = REQ;
                        end else if (memRd) begin
                            oStall    = 1'b1;
                            nextState = RESP;
                        end
                    end else if (iBustoReg) begin
                        oBusReq   = 1'b1;
                        oStall    = 1'b1;
                        nextState = BUS;
                    end else begin
                        wbEnNext = iAlutoReg;
                    end
                end
                REQ: begin
                    if (iMemGnt) begin
                        oMemReq = 1'b1;
                        oMemWe  = memWr;
                        if (memRd) begin
                            oStall    = 1'b1;
                            nextState = RESP;
                        end else begin
                            nextState = IDLE;
                        end
                    end else if (timeoutHit) begin
                        abortNow  = 1'b1;
                        nextState = IDLE;
                    end else begin
                        oMemReq = 1'b1;
                        oMemWe  = memWr;
                        oStall  = 1'b1;
                    end
                end
                RESP: begin
                    if (iMemRvalid) begin
                        wbDataNext = iMemRdata;
                        wbEnNext   = 1'b1;
                        nextState  = IDLE;
                    end else if (timeoutHit) begin
                        abortNow  = 1'b1;
                        nextState = IDLE;
                    end else begin
                        oStall = 1'b1;
                    end
                end
                BUS: begin
                    if (iBusValid) begin
                        oBusReq    = 1'b1;
                        wbDataNext = iBusData;
                        wbEnNext   = 1'b1;
                        nextState  = IDLE;
                    end else if (timeoutHit) begin
                        abortNow  = 1'b1;
                        nextState = IDLE;
                    end else begin
                        oBusReq = 1'b1;
                        oStall  = 1'b1;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Build with MEM_TIMEOUT_EN defined to exercise the timeout abort.
// In the default build the bench checks the indefinite wait instead.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] iAluOut;
    logic [15:0] iData2;
    logic [3:0]  iDest;
    logic        iAlutoReg;
    logic        iMemtoReg;
    logic        iBustoReg;
    logic        iMemRead;
    logic        iMemWrite;
    logic        oStall;
    logic        oMemReq;
    logic        oMemWe;
    logic [15:0] oMemAddr;
    logic [15:0] oMemWdata;
    logic        iMemGnt;
    logic        iMemRvalid;
    logic [15:0] iMemRdata;
    logic        oBusReq;
    logic [15:0] oBusAddr;
    logic        iBusValid;
    logic [15:0] iBusData;
    logic [15:0] oWbData;
    logic [3:0]  oWbDest;
    logic        oWbEn;
    logic        oMemErr;

    int checks;
    int failures;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iAluOut    (iAluOut),
        .iData2     (iData2),
        .iDest      (iDest),
        .iAlutoReg  (iAlutoReg),
        .iMemtoReg  (iMemtoReg),
        .iBustoReg  (iBustoReg),
        .iMemRead   (iMemRead),
        .iMemWrite  (iMemWrite),
        .oStall     (oStall),
        .oMemReq    (oMemReq),
        .oMemWe     (oMemWe),
        .oMemAddr   (oMemAddr),
        .oMemWdata  (oMemWdata),
        .iMemGnt    (iMemGnt),
        .iMemRvalid (iMemRvalid),
        .iMemRdata  (iMemRdata),
        .oBusReq    (oBusReq),
        .oBusAddr   (oBusAddr),
        .iBusValid  (iBusValid),
        .iBusData   (iBusData),
        .oWbData    (oWbData),
        .oWbDest    (oWbDest),
        .oWbEn      (oWbEn),
        .oMemErr    (oMemErr)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearInputs();
        iAluOut    = 16'h0000;
        iData2     = 16'h0000;
        iDest      = 4'd0;
        iAlutoReg  = 1'b0;
        iMemtoReg  = 1'b0;
        iBustoReg  = 1'b0;
        iMemRead   = 1'b0;
        iMemWrite  = 1'b0;
        iMemGnt    = 1'b0;
        iMemRvalid = 1'b0;
        iMemRdata  = 16'h0000;
        iBusValid  = 1'b0;
        iBusData   = 16'h0000;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        rst_n    = 1'b0;
        iMemRead = 1'b1;
        #2;
        checks++;
        if (oMemReq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_memreq: got %0b want 0", oMemReq);
        end
        checks++;
        if (oStall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stall: got %0b want 0", oStall);
        end
        nextCycle();
        nextCycle();
        checks++;
        if (oWbData !== 16'h0000 || oWbDest !== 4'd0 || oWbEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_wb: got data=%h dest=%0d en=%0b want 0/0/0", oWbData, oWbDest, oWbEn);
        end
        checks++;
        if (oMemErr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_err: got %0b want 0", oMemErr);
        end
        iMemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
    endtask

    task automatic test_alu();
        clearInputs();
        iAluOut   = 16'h1234;
        iDest     = 4'd3;
        iAlutoReg = 1'b1;
        @(negedge clk);
        checks++;
        if (oStall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_stall: got %0b want 0", oStall);
        end
        nextCycle();
        checks++;
        if (oWbData !== 16'h1234 || oWbDest !== 4'd3 || oWbEn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL alu_wb: got data=%h dest=%0d en=%0b want 1234/3/1", oWbData, oWbDest, oWbEn);
        end
        iAluOut   = 16'h0777;
        iDest     = 4'd9;
        iAlutoReg = 1'b0;
        nextCycle();
        checks++;
        if (oWbData !== 16'h0777 || oWbDest !== 4'd9 || oWbEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_noreg: got data=%h dest=%0d en=%0b want 0777/9/0", oWbData, oWbDest, oWbEn);
        end
    endtask

    task automatic test_write();
        clearInputs();
        iAluOut   = 16'h4321;
        iDest     = 4'd1;
        iAlutoReg = 1'b1;
        nextCycle();
        clearInputs();
        iAluOut   = 16'h0040;
        iData2    = 16'hBEEF;
        iMemWrite = 1'b1;
        iMemGnt   = 1'b1;
        @(negedge clk);
        checks++;
        if (oMemReq !== 1'b1 || oMemWe !== 1'b1 || oStall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_ctrl: got req=%0b we=%0b stall=%0b want 1/1/0", oMemReq, oMemWe, oStall);
        end
        checks++;
        if (oMemAddr !== 16'h0040 || oMemWdata !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL write_bus: got addr=%h wdata=%h want 0040/BEEF", oMemAddr, oMemWdata);
        end
        nextCycle();
        clearInputs();
        checks++;
        if (oWbEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_wben: got %0b want 0", oWbEn);
        end
        @(negedge clk);
        checks++;
        if (oMemReq !== 1'b0 || oStall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_done: got req=%0b stall=%0b want 0/0", oMemReq, oStall);
        end
        nextCycle();
    endtask

    task automatic test_read();
        clearInputs();
        iAluOut  = 16'h0010;
        iDest    = 4'd7;
        iMemRead = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            iMemGnt    = (c == 2);
            iMemRvalid = (c == 1) || (c == 4);
            iMemRdata  = (c == 4) ? 16'hA5A5 : 16'h1111;
            @(negedge clk);
            checks++;
            if (oStall !== (c < 4)) begin
                failures++;
                $display("[TB] FAIL read_stall c=%0d: got %0b want %0b", c, oStall, (c < 4));
            end
            checks++;
            if (oMemReq !== (c <= 2) || oMemWe !== 1'b0) begin
                failures++;
                $display("[TB] FAIL read_req c=%0d: got req=%0b we=%0b want %0b/0", c, oMemReq, oMemWe, (c <= 2));
            end
            nextCycle();
            if (c < 4) begin
                checks++;
                if (oWbEn !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL read_bubble c=%0d: got %0b want 0", c, oWbEn);
                end
            end
        end
        checks++;
        if (oWbData !== 16'hA5A5 || oWbDest !== 4'd7 || oWbEn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL read_wb: got data=%h dest=%0d en=%0b want A5A5/7/1", oWbData, oWbDest, oWbEn);
        end
        clearInputs();
        nextCycle();
    endtask

    task automatic test_bus();
        clearInputs();
        iAluOut   = 16'h0200;
        iDest     = 4'd5;
        iBustoReg = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            iBusValid = (c == 0) || (c == 3);
            iBusData  = (c == 3) ? 16'h00FF : 16'hDEAD;
            @(negedge clk);
            checks++;
            if (oBusReq !== 1'b1 || oBusAddr !== 16'h0200) begin
                failures++;
                $display("[TB] FAIL bus_req c=%0d: got req=%0b addr=%h want 1/0200", c, oBusReq, oBusAddr);
            end
            checks++;
            if (oStall !== (c < 3)) begin
                failures++;
                $display("[TB] FAIL bus_stall c=%0d: got %0b want %0b", c, oStall, (c < 3));
            end
            nextCycle();
        end
        checks++;
        if (oWbData !== 16'h00FF || oWbDest !== 4'd5 || oWbEn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bus_wb: got data=%h dest=%0d en=%0b want 00FF/5/1", oWbData, oWbDest, oWbEn);
        end
        clearInputs();
        @(negedge clk);
        checks++;
        if (oBusReq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bus_done: got %0b want 0", oBusReq);
        end
        nextCycle();
    endtask

    task automatic test_back_to_back();
        clearInputs();
        iAluOut   = 16'h0044;
        iData2    = 16'h1357;
        iMemWrite = 1'b1;
        iMemGnt   = 1'b1;
        nextCycle();
        clearInputs();
        iAluOut   = 16'hCAFE;
        iDest     = 4'd2;
        iAlutoReg = 1'b1;
        nextCycle();
        checks++;
        if (oWbData !== 16'hCAFE || oWbDest !== 4'd2 || oWbEn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_alu: got data=%h dest=%0d en=%0b want CAFE/2/1", oWbData, oWbDest, oWbEn);
        end
        clearInputs();
        iAluOut   = 16'h0080;
        iDest     = 4'd4;
        iMemRead  = 1'b1;
        iMemWrite = 1'b1;
        iBustoReg = 1'b1;
        iAlutoReg = 1'b1;
        iMemGnt   = 1'b1;
        @(negedge clk);
        checks++;
        if (oMemReq !== 1'b1 || oMemWe !== 1'b0 || oBusReq !== 1'b0 || oStall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL prio_ctrl: got req=%0b we=%0b bus=%0b stall=%0b want 1/0/0/1", oMemReq, oMemWe, oBusReq, oStall);
        end
        nextCycle();
        iMemGnt    = 1'b0;
        iMemRvalid = 1'b1;
        iMemRdata  = 16'h5A5A;
        @(negedge clk);
        checks++;
        if (oStall !== 1'b0 || oMemReq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL prio_resp: got stall=%0b req=%0b want 0/0", oStall, oMemReq);
        end
        nextCycle();
        checks++;
        if (oWbData !== 16'h5A5A || oWbDest !== 4'd4 || oWbEn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL prio_wb: got data=%h dest=%0d en=%0b want 5A5A/4/1", oWbData, oWbDest, oWbEn);
        end
        clearInputs();
        nextCycle();
    endtask

    task automatic test_reset_mid_access();
        clearInputs();
        iAluOut   = 16'h0099;
        iDest     = 4'd6;
        iAlutoReg = 1'b1;
        nextCycle();
        clearInputs();
        iAluOut  = 16'h0020;
        iDest    = 4'd8;
        iMemRead = 1'b1;
        iMemGnt  = 1'b1;
        nextCycle();
        iMemGnt = 1'b0;
        @(negedge clk);
        checks++;
        if (oStall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_pre: got stall=%0b want 1", oStall);
        end
        rst_n = 1'b0;
        clearInputs();
        #1;
        checks++;
        if (oStall !== 1'b0 || oMemReq !== 1'b0 || oBusReq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_comb: got stall=%0b req=%0b bus=%0b want 0/0/0", oStall, oMemReq, oBusReq);
        end
        checks++;
        if (oWbData !== 16'h0000 || oWbEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_wb: got data=%h en=%0b want 0000/0", oWbData, oWbEn);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        iAluOut    = 16'h0011;
        iMemRvalid = 1'b1;
        iMemRdata  = 16'h7777;
        nextCycle();
        checks++;
        if (oWbEn !== 1'b0 || oWbData !== 16'h0011) begin
            failures++;
            $display("[TB] FAIL rstmid_late: got data=%h en=%0b want 0011/0", oWbData, oWbEn);
        end
        clearInputs();
        nextCycle();
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        clearInputs();
        iAluOut   = 16'h0300;
        iData2    = 16'h2468;
        iMemWrite = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (oStall !== (c < 5) || oMemReq !== (c < 5)) begin
                failures++;
                $display("[TB] FAIL tmo_wait c=%0d: got stall=%0b req=%0b want %0b", c, oStall, oMemReq, (c < 5));
            end
            nextCycle();
        end
        checks++;
        if (oMemErr !== 1'b1 || oWbEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tmo_abort: got err=%0b en=%0b want 1/0", oMemErr, oWbEn);
        end
        clearInputs();
        iAluOut   = 16'h0BAD;
        iDest     = 4'd10;
        iAlutoReg = 1'b1;
        nextCycle();
        checks++;
        if (oWbData !== 16'h0BAD || oWbEn !== 1'b1 || oMemErr !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tmo_resume: got data=%h en=%0b err=%0b want 0BAD/1/1", oWbData, oWbEn, oMemErr);
        end
        clearInputs();
        nextCycle();
    endtask
`else
    task automatic test_timeout();
        clearInputs();
        iAluOut   = 16'h0300;
        iData2    = 16'h2468;
        iMemWrite = 1'b1;
        for (int c = 0; c < 10; c++) begin
            nextCycle();
        end
        @(negedge clk);
        checks++;
        if (oStall !== 1'b1 || oMemReq !== 1'b1 || oMemErr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nowait_hold: got stall=%0b req=%0b err=%0b want 1/1/0", oStall, oMemReq, oMemErr);
        end
        nextCycle();
        iMemGnt = 1'b1;
        @(negedge clk);
        checks++;
        if (oStall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nowait_gnt: got stall=%0b want 0", oStall);
        end
        nextCycle();
        clearInputs();
        nextCycle();
    endtask
`endif

    // Run each scenario in sequence, then report the totals.
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clearInputs();
        test_reset();
        test_alu();
        test_write();
        test_read();
        test_bus();
        test_back_to_back();
        test_reset_mid_access();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
